// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU request sequencer: opcode encodings, the idle
// opcode parked on the ALU when no request is issued, flag bit positions in
// the packed flag nibble, and the packed response layout.
package alu_seq_pkg;

   // ALU opcodes understood by the downstream ALU
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_SRL  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_ROR  = 4'd6;
   localparam logic [3:0] OP_SGT  = 4'd7;
   localparam logic [3:0] OP_IDLE = 4'hF;

   // Bit positions inside the 4-bit flag field {carry, zero, ovf, sign}
   localparam int FLAG_CARRY = 3;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_SIGN  = 0;
   localparam int FLAGS_W    = 4;

   // Packed response entry is {result, flags, tag}, tag in the LSBs
   function automatic int resp_width(input int width, input int tag_w);
      return width + FLAGS_W + tag_w;
   endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous response FIFO for the ALU request sequencer. The head entry is
// presented combinationally; a push and a pop in the same cycle are accepted
// even when full, leaving the count unchanged.
module alu_seq_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   // A pop on a full FIFO frees the slot the simultaneous push writes into
   assign w_do_push = i_push && (!w_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write
   // NOTE: the storage array has no reset; validity is carried by the count
   // and pointers, so clearing it would only cost flops.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/alu_req_sequencer.sv
// Flow-controlled front end for the pipelined ALU. Requests are registered
// onto the ALU ports, their tags ride a valid/tag pipeline matching the ALU
// latency, and results are captured into a response FIFO returned in issue
// order. Credit-based req_ready guarantees the FIFO can never overflow.
// Optional build macro ALU_SEQ_STATS_EN adds saturating issue/stall counters.
module alu_req_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ALU_LAT    = 2,
   parameter int RESP_DEPTH = 8,
   parameter int TAG_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   // request side
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [3:0]        i_req_opcode,
   input  logic [WIDTH-1:0]  i_req_a,
   input  logic [WIDTH-1:0]  i_req_b,
   input  logic [4:0]        i_req_shift,
   input  logic [TAG_W-1:0]  i_req_tag,
   // ALU drive and return
   output logic [3:0]        o_alu_opcode,
   output logic [WIDTH-1:0]  o_alu_in1,
   output logic [WIDTH-1:0]  o_alu_in2,
   output logic [4:0]        o_alu_shift,
   input  logic [WIDTH-1:0]  i_alu_result,
   input  logic              i_alu_carry,
   input  logic              i_alu_zero,
   input  logic              i_alu_ovf,
   input  logic              i_alu_sign,
   // response side
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [WIDTH-1:0]  o_resp_result,
   output logic [3:0]        o_resp_flags,
   output logic [TAG_W-1:0]  o_resp_tag
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0]       o_issue_count,
   output logic [15:0]       o_stall_count
`endif
);

   localparam int RESP_W = resp_width(WIDTH, TAG_W);
   localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

   logic                r_alu_opcode_valid_unused;
   logic [3:0]          r_alu_opcode;
   logic [WIDTH-1:0]    r_alu_in1;
   logic [WIDTH-1:0]    r_alu_in2;
   logic [4:0]          r_alu_shift;

   logic [ALU_LAT:0]    r_tp_valid;
   logic [TAG_W-1:0]    r_tp_tag [ALU_LAT+1];

   logic                w_accept;
   logic                w_req_ready;
   logic [31:0]         w_inflight;
   logic [31:0]         w_occupancy;
   logic [FLAGS_W-1:0]  w_flags;
   logic [RESP_W-1:0]   w_push_data;
   logic [RESP_W-1:0]   w_head;
   logic [CNT_W-1:0]    w_fifo_count;
   logic                w_fifo_empty;
   logic                w_resp_valid;
   logic                w_pop;

   assign r_alu_opcode_valid_unused = 1'b0;

   assign w_accept = i_req_valid && w_req_ready;

   // Credit: queued responses plus every operation still travelling the ALU
   always_comb begin
      // NOTE: every combinational output gets a default before any branch or
      // loop so no path leaves it unassigned and infers a latch.
      w_inflight = '0;
      for (int i = 0; i <= ALU_LAT; i++) begin
         w_inflight = w_inflight + 32'(r_tp_valid[i]);
      end
      w_occupancy = 32'(w_fifo_count) + w_inflight;
      w_req_ready = (w_occupancy < 32'(RESP_DEPTH));
   end

   assign o_req_ready = w_req_ready;

   // Drive the ALU from registers: the accepted request, else the idle opcode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_opcode <= OP_IDLE;
         r_alu_in1    <= '0;
         r_alu_in2    <= '0;
         r_alu_shift  <= '0;
      end else if (w_accept) begin
         r_alu_opcode <= i_req_opcode;
         r_alu_in1    <= i_req_a;
         r_alu_in2    <= i_req_b;
         r_alu_shift  <= i_req_shift;
      end else begin
         r_alu_opcode <= OP_IDLE;
         r_alu_in1    <= '0;
         r_alu_in2    <= '0;
         r_alu_shift  <= '0;
      end
   end

   assign o_alu_opcode = r_alu_opcode;
   assign o_alu_in1    = r_alu_in1;
   assign o_alu_in2    = r_alu_in2;
   assign o_alu_shift  = r_alu_shift;

   // Tag pipeline: stage ALU_LAT lines up with the ALU result for that request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tp_valid <= '0;
         for (int i = 0; i <= ALU_LAT; i++) begin
            r_tp_tag[i] <= '0;
         end
      end else begin
         r_tp_valid  <= {r_tp_valid[ALU_LAT-1:0], w_accept};
         r_tp_tag[0] <= i_req_tag;
         for (int i = 1; i <= ALU_LAT; i++) begin
            r_tp_tag[i] <= r_tp_tag[i-1];
         end
      end
   end

   // Pack ALU flags into their fixed nibble positions, forwarded verbatim
   always_comb begin
      w_flags             = '0;
      w_flags[FLAG_CARRY] = i_alu_carry;
      w_flags[FLAG_ZERO]  = i_alu_zero;
      w_flags[FLAG_OVF]   = i_alu_ovf;
      w_flags[FLAG_SIGN]  = i_alu_sign;
   end

   assign w_push_data = {i_alu_result, w_flags, r_tp_tag[ALU_LAT]};
   assign w_pop       = w_resp_valid && i_resp_ready;

   alu_seq_fifo #(
      .DATA_W (RESP_W),
      .DEPTH  (RESP_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_tp_valid[ALU_LAT]),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   // Head of the FIFO drives the response; outputs read zero while empty
   assign w_resp_valid  = !w_fifo_empty;
   assign o_resp_valid  = w_resp_valid;
   assign o_resp_result = w_resp_valid ? w_head[RESP_W-1 -: WIDTH] : '0;
   assign o_resp_flags  = w_resp_valid ? w_head[TAG_W +: FLAGS_W] : '0;
   assign o_resp_tag    = w_resp_valid ? w_head[TAG_W-1:0] : '0;

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] r_issue_count;
   logic [15:0] r_stall_count;

   // Saturating accept and back-pressure counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_accept && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'd1;
         end
         if (i_req_valid && !w_req_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end

   assign o_issue_count = r_issue_count;
   assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer: a behavioural pipelined ALU is
// attached to the DUT, and every accepted request is turned into an expected
// response pushed into an in-order queue that the returned responses must match.
module tb_alu_req_sequencer;
   import alu_seq_pkg::*;

   localparam int WIDTH      = 8;
   localparam int ALU_LAT    = 2;
   localparam int RESP_DEPTH = 8;
   localparam int TAG_W      = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic [3:0]       req_opcode = '0;
   logic [7:0]       req_a = '0;
   logic [7:0]       req_b = '0;
   logic [4:0]       req_shift = '0;
   logic [3:0]       req_tag = '0;
   logic             resp_ready = 1'b0;
   logic             o_req_ready;
   logic [3:0]       o_alu_opcode;
   logic [7:0]       o_alu_in1;
   logic [7:0]       o_alu_in2;
   logic [4:0]       o_alu_shift;
   logic [7:0]       alu_result;
   logic             alu_carry, alu_zero, alu_ovf, alu_sign;
   logic             o_resp_valid;
   logic [7:0]       o_resp_result;
   logic [3:0]       o_resp_flags;
   logic [3:0]       o_resp_tag;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0]      o_issue_count;
   logic [15:0]      o_stall_count;
`endif

   always #5 clk = ~clk;

   alu_req_sequencer #(
      .WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .RESP_DEPTH(RESP_DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_valid   (req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_opcode  (req_opcode),
      .i_req_a       (req_a),
      .i_req_b       (req_b),
      .i_req_shift   (req_shift),
      .i_req_tag     (req_tag),
      .o_alu_opcode  (o_alu_opcode),
      .o_alu_in1     (o_alu_in1),
      .o_alu_in2     (o_alu_in2),
      .o_alu_shift   (o_alu_shift),
      .i_alu_result  (alu_result),
      .i_alu_carry   (alu_carry),
      .i_alu_zero    (alu_zero),
      .i_alu_ovf     (alu_ovf),
      .i_alu_sign    (alu_sign),
      .o_resp_valid  (o_resp_valid),
      .i_resp_ready  (resp_ready),
      .o_resp_result (o_resp_result),
      .o_resp_flags  (o_resp_flags),
      .o_resp_tag    (o_resp_tag)
`ifdef ALU_SEQ_STATS_EN
      ,
      .o_issue_count (o_issue_count),
      .o_stall_count (o_stall_count)
`endif
   );

   // Behavioural ALU function: returns {result, carry, zero, ovf, sign}
   function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [4:0] sh);
      logic [8:0]  w;
      logic [15:0] m;
      logic [15:0] d;
      logic [7:0]  r;
      logic        c;
      logic        v;
      r = '0; c = 1'b0; v = 1'b0; w = '0; m = '0; d = '0;
      case (op)
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_SUB: begin
            w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         OP_MUL: begin
            m = 16'(a) * 16'(b); r = m[7:0]; c = |m[15:8];
         end
         OP_AND: r = a & b;
         OP_SRL: r = a >> sh;
         OP_SLT: r = {7'd0, ($signed(a) < $signed(b))};
         OP_ROR: begin
            d = {a, a} >> sh[2:0]; r = d[7:0];
         end
         OP_SGT: r = {7'd0, ($signed(a) > $signed(b))};
         default: r = 8'h00;
      endcase
      return {r, c, (r == 8'h00), v, r[7]};
   endfunction

   // ALU model: ALU_LAT registered stages, reset together with the DUT
   logic [11:0] alu_pipe [ALU_LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ALU_LAT; i++) alu_pipe[i] <= '0;
      end else begin
         alu_pipe[0] <= alu_ref(o_alu_opcode, o_alu_in1, o_alu_in2, o_alu_shift);
         for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
      end
   end
   assign {alu_result, alu_carry, alu_zero, alu_ovf, alu_sign} = alu_pipe[ALU_LAT-1];

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_acc = 0;
   int          n_resp = 0;
   int          exp_issue = 0;
   int          exp_stall = 0;
   logic [15:0] exp_q [$];
   logic        hold_pending = 1'b0;
   logic [15:0] hold_snap = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // One clock: drive inputs at the negedge, score the handshakes that the
   // coming edge will complete, then advance to the next negedge.
   task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [4:0] sh, input logic [3:0] tg,
                       input logic rr);
      logic [15:0] e;
      req_valid = v; req_opcode = op; req_a = a; req_b = b;
      req_shift = sh; req_tag = tg; resp_ready = rr;
      #1;
      if (hold_pending)
         check("resp_hold", 32'({o_resp_result, o_resp_flags, o_resp_tag}), 32'(hold_snap));
      if (v && o_req_ready) begin
         exp_q.push_back({alu_ref(op, a, b, sh), tg});
         n_acc++;
         if (exp_issue < 65535) exp_issue++;
      end else if (v) begin
         if (exp_stall < 65535) exp_stall++;
      end
      if (o_resp_valid && rr) begin
         if (exp_q.size() == 0) begin
            check("resp_spurious", 32'(o_resp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp", 32'({o_resp_result, o_resp_flags, o_resp_tag}), 32'(e));
         end
         n_resp++;
      end
      hold_pending = o_resp_valid && !rr;
      hold_snap    = {o_resp_result, o_resp_flags, o_resp_tag};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 4'd0, 8'd0, 8'd0, 5'd0, 4'd0, rr);
   endtask

   task automatic rand_step(input logic v, input logic rr, input logic [3:0] tg);
      step(v, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 5'($urandom), tg, rr);
   endtask

   task automatic do_reset();
      req_valid = 1'b0; resp_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      hold_pending = 1'b0;
      exp_issue = 0;
      exp_stall = 0;
      @(negedge clk);
   endtask

   initial begin
      int r0;
      int a0;

      // Reset values
      do_reset();
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst_resp_fields", 32'({o_resp_result, o_resp_flags, o_resp_tag}), 32'd0);
      check("rst_alu_opcode", 32'(o_alu_opcode), 32'hF);
      check("rst_alu_ops", 32'({o_alu_in1, o_alu_in2, o_alu_shift}), 32'd0);

      // Single ADD 0xFF + 0x01, tag 3: response exactly three edges later
      step(1'b1, OP_ADD, 8'hFF, 8'h01, 5'd0, 4'd3, 1'b0);
      check("add_alu_drive", 32'({o_alu_opcode, o_alu_in1, o_alu_in2}), 32'h0FF01);
      for (int k = 1; k <= 3; k++) begin
         idle(1'b0);
         if (k == 1) check("idle_alu_opcode", 32'(o_alu_opcode), 32'hF);
         check($sformatf("add_latency_%0d", k), 32'(o_resp_valid), 32'(k == 3));
      end
      check("add_result", 32'(o_resp_result), 32'h00);
      check("add_carry", 32'(o_resp_flags[FLAG_CARRY]), 32'd1);
      check("add_tag", 32'(o_resp_tag), 32'd3);
      idle(1'b1);
      check("add_popped", 32'(o_resp_valid), 32'd0);

      // Back-to-back: eight issues on consecutive cycles, eight consecutive responses
      r0 = n_resp;
      for (int i = 0; i < 8; i++) begin
         check("b2b_ready", 32'(o_req_ready), 32'd1);
         rand_step(1'b1, 1'b1, 4'(i));
      end
      check("b2b_resp_during_issue", 32'(n_resp - r0), 32'd4);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("b2b_resp_total", 32'(n_resp - r0), 32'd8);

      // Flood with responses blocked: exactly RESP_DEPTH accepts
      do_reset();
      a0 = n_acc;
      for (int i = 0; i < 12; i++) rand_step(1'b1, 1'b0, 4'(i));
      check("flood_accepts", 32'(n_acc - a0), 32'(RESP_DEPTH));
      check("flood_ready_low", 32'(o_req_ready), 32'd0);
`ifdef ALU_SEQ_STATS_EN
      check("stats_issue", 32'(o_issue_count), 32'(exp_issue));
      check("stats_stall", 32'(o_stall_count), 32'(exp_stall));
`endif
      r0 = n_resp;
      for (int i = 0; i < 12; i++) idle(1'b1);
      check("drain_count", 32'(n_resp - r0), 32'(RESP_DEPTH));
      check("drain_ready_back", 32'(o_req_ready), 32'd1);

      // Unused opcode 4'hA is forwarded and returns the ALU's default
      step(1'b1, 4'hA, 8'($urandom), 8'($urandom), 5'($urandom), 4'd9, 1'b0);
      check("opA_alu_opcode", 32'(o_alu_opcode), 32'hA);
      for (int i = 0; i < 3; i++) idle(1'b0);
      check("opA_valid", 32'(o_resp_valid), 32'd1);
      check("opA_result", 32'(o_resp_result), 32'h00);
      idle(1'b1);

      // Reset with two in flight and three queued; nothing stale afterwards
      for (int i = 0; i < 5; i++) rand_step(1'b1, 1'b0, 4'(i + 1));
      idle(1'b0);
      check("pre_rst_valid", 32'(o_resp_valid), 32'd1);
      do_reset();
      check("post_rst_valid", 32'(o_resp_valid), 32'd0);
      check("post_rst_ready", 32'(o_req_ready), 32'd1);
      r0 = n_resp;
      for (int i = 0; i < 10; i++) idle(1'b1);
      check("post_rst_no_stale", 32'(n_resp - r0), 32'd0);

      // Randomised traffic with random back-pressure
      for (int i = 0; i < 400; i++)
         rand_step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 4'($urandom));
      for (int i = 0; i < 30; i++) idle(1'b1);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      check("rand_resp_valid", 32'(o_resp_valid), 32'd0);
`ifdef ALU_SEQ_STATS_EN
      check("rand_stats_issue", 32'(o_issue_count), 32'(exp_issue));
      check("rand_stats_stall", 32'(o_stall_count), 32'(exp_stall));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
